p2_bus_decode: RTL and testbench

Parametrised P2-bus slave decoder and cycle controller, the successor to the fixed four-way P2 address decode. It sits between the P2 bus master and up to NSLAVE on-board slaves (RAM, frame buffer, keyboard SCC, video control, …), matches each bus cycle against programmable base/mask windows, and drives a one-hot slave select. It holds the master in `wait_n` until the selected slave acknowledges, muxes read data back, and flags unmapped or timed-out cycles as bus errors.

---
 rtl/p2_bus_decode.sv | 185 ++++++++++++++++++
 tb/tb_p2_bus_decode.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/p2_bus_decode.sv
`default_nettype none
// ============================================================================
// Module      : p2_bus_decode
// Description : P2-bus slave decoder and cycle controller with base/mask
//               windows, one-hot select, wait-state hold and bus error.
//               Optional macro P2_BUS_TIMEOUT_EN adds the SEL timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module p2_bus_decode #(
    parameter int                   NSLAVE  = 4,
    parameter int                   AW      = 23,
    parameter int                   DW      = 16,
    parameter logic [NSLAVE*AW-1:0] BASE    = {23'h781800, 23'h780000, 23'h700000, 23'h000000},
    parameter logic [NSLAVE*AW-1:0] MASK    = {23'h7FF800, 23'h7FF000, 23'h7F0000, 23'h7F0000},
    parameter int                   TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        addr,
    input  logic                 go_n,
    input  logic                 rw_n,
    input  logic                 wel_n,
    input  logic                 weu_n,
    output logic                 wait_n,
    output logic                 berr_n,
    output logic [NSLAVE-1:0]    sel,
    output logic [AW-1:0]        lat_addr,
    output logic                 lat_rw_n,
    output logic [1:0]           lat_be_n,
    input  logic [NSLAVE-1:0]    slv_ack,
    input  logic [NSLAVE*DW-1:0] slv_rdata,
    output logic [DW-1:0]        rdata
);

    localparam int c_IW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEL  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [1:0] c_ST_ERR  = 2'd3;

    logic [1:0]        r_state;
    logic [NSLAVE-1:0] r_sel;
    logic [c_IW-1:0]   r_win;
    logic              r_wait_n;
    logic              r_berr_n;
    logic [AW-1:0]     r_lat_addr;
    logic              r_lat_rw_n;
    logic [1:0]        r_lat_be_n;
    logic [DW-1:0]     r_rdata;

    logic [NSLAVE-1:0] w_hit;
    logic [NSLAVE-1:0] w_onehot;
    logic [c_IW-1:0]   w_win;
    logic              w_any;
    logic              w_ack;
    logic              w_timeout;
    logic [DW-1:0]     w_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NSLAVE; gi++) begin : g_hit
            assign w_hit[gi] = ((addr & MASK[gi*AW +: AW]) ==
                                (BASE[gi*AW +: AW] & MASK[gi*AW +: AW]));
        end
    endgenerate

    // Overlapping windows resolve to the lowest index.
    always_comb begin
        logic v_found;
        v_found  = 1'b0;
        w_onehot = '0;
        w_win    = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (w_hit[i] && !v_found) begin
                v_found     = 1'b1;
                w_onehot[i] = 1'b1;
                w_win       = i[c_IW-1:0];
            end
        end
    end

    assign w_any   = |w_hit;
    assign w_ack   = |(r_sel & slv_ack);
    assign w_rdata = slv_rdata[r_win*DW +: DW];

`ifdef P2_BUS_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Counts cycles spent in SEL; cleared whenever the cycle leaves SEL.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if ((r_state == c_ST_SEL) && !w_ack && !w_timeout) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    assign w_timeout = (r_state == c_ST_SEL) && (r_cnt == c_TO_LAST);
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_sel      <= '0;
            r_win      <= '0;
            r_wait_n   <= 1'b1;
            r_berr_n   <= 1'b1;
            r_lat_addr <= '0;
            r_lat_rw_n <= 1'b0;
            r_lat_be_n <= 2'b00;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!go_n) begin
                        r_lat_addr <= addr;
                        r_lat_rw_n <= rw_n;
                        r_lat_be_n <= {weu_n, wel_n};
                        r_win      <= w_win;
                        r_wait_n   <= 1'b0;
                        if (w_any) begin
                            r_sel   <= w_onehot;
                            r_state <= c_ST_SEL;
                        end else begin
                            r_state <= c_ST_ERR;
                        end
                    end
                end
                c_ST_SEL: begin
                    if (w_ack) begin
                        if (r_lat_rw_n) begin
                            r_rdata <= w_rdata;
                        end
                        r_sel    <= '0;
                        r_wait_n <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end else if (w_timeout) begin
                        r_sel    <= '0;
                        r_wait_n <= 1'b1;
                        r_berr_n <= 1'b0;
                        r_state  <= c_ST_ERR;
                    end
                end
                c_ST_DONE: begin
                    if (go_n) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_ERR: begin
                    // An unmapped cycle arrives here with berr_n still high;
                    // flag it one clock after acceptance before honouring go_n.
                    if (r_berr_n) begin
                        r_berr_n <= 1'b0;
                        r_wait_n <= 1'b1;
                    end else if (go_n) begin
                        r_berr_n <= 1'b1;
                        r_state  <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign wait_n   = r_wait_n;
    assign berr_n   = r_berr_n;
    assign sel      = r_sel;
    assign lat_addr = r_lat_addr;
    assign lat_rw_n = r_lat_rw_n;
    assign lat_be_n = r_lat_be_n;
    assign rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_p2_bus_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_p2_bus_decode
// Description : Self-checking bench for p2_bus_decode: directed cases plus
//               random bus cycles against a transaction-level decode model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p2_bus_decode;

    localparam int TB_TO = 4;
`ifdef P2_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [91:0] TB_BASE    = {23'h781800, 23'h780000, 23'h700000, 23'h000000};
    localparam logic [91:0] TB_MASK    = {23'h7FF800, 23'h7FF000, 23'h7F0000, 23'h7F0000};
    localparam logic [91:0] TB_MASK_OV = {23'h7FF800, 23'h7FF000, 23'h000000, 23'h000000};

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] addr;
    logic        go_n, go_n_ov, rw_n, wel_n, weu_n;
    logic [3:0]  slv_ack, slv_ack_ov;
    logic [63:0] slv_rdata, slv_rdata_ov;

    logic        wait_n, berr_n, lat_rw_n;
    logic [3:0]  sel;
    logic [22:0] lat_addr;
    logic [1:0]  lat_be_n;
    logic [15:0] rdata;

    logic        wait_n_ov, berr_n_ov, lat_rw_n_ov;
    logic [3:0]  sel_ov;
    logic [22:0] lat_addr_ov;
    logic [1:0]  lat_be_n_ov;
    logic [15:0] rdata_ov;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_rdata = 16'h0000;

    always #5 clk = ~clk;

    p2_bus_decode #(
        .NSLAVE(4), .AW(23), .DW(16), .BASE(TB_BASE), .MASK(TB_MASK), .TIMEOUT(TB_TO)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .go_n(go_n), .rw_n(rw_n),
        .wel_n(wel_n), .weu_n(weu_n), .wait_n(wait_n), .berr_n(berr_n), .sel(sel),
        .lat_addr(lat_addr), .lat_rw_n(lat_rw_n), .lat_be_n(lat_be_n),
        .slv_ack(slv_ack), .slv_rdata(slv_rdata), .rdata(rdata)
    );

    p2_bus_decode #(
        .NSLAVE(4), .AW(23), .DW(16), .BASE(TB_BASE), .MASK(TB_MASK_OV), .TIMEOUT(TB_TO)
    ) dut_ov (
        .clk(clk), .reset(reset), .addr(addr), .go_n(go_n_ov), .rw_n(rw_n),
        .wel_n(wel_n), .weu_n(weu_n), .wait_n(wait_n_ov), .berr_n(berr_n_ov), .sel(sel_ov),
        .lat_addr(lat_addr_ov), .lat_rw_n(lat_rw_n_ov), .lat_be_n(lat_be_n_ov),
        .slv_ack(slv_ack_ov), .slv_rdata(slv_rdata_ov), .rdata(rdata_ov)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lowest-numbered matching window, or -1 when the address is unmapped.
    function automatic int find_win(input logic [22:0] a, input logic [91:0] bp,
                                    input logic [91:0] mp);
        logic [22:0] b, m;
        for (int i = 0; i < 4; i++) begin
            b = bp[i*23 +: 23];
            m = mp[i*23 +: 23];
            if ((a & m) == (b & m)) return i;
        end
        return -1;
    endfunction

    // One complete bus cycle on dut, starting and ending in IDLE at a negedge.
    // k: clock edge after acceptance on which the winner acks.
    task automatic do_txn(input logic [22:0] a, input bit rd, input bit wel, input bit weu,
                          input int k, input logic [15:0] d, input int hold, input bit noise);
        int          win, c, j;
        bit          erred;
        logic [3:0]  xsel;
        logic [63:0] bus;
        win   = find_win(a, TB_BASE, TB_MASK);
        xsel  = (win >= 0) ? 4'(1 << win) : 4'b0000;
        erred = 1'b0;
        addr = a; rw_n = rd; wel_n = wel; weu_n = weu; go_n = 1'b0;
        @(negedge clk);
        chk("acc_wait_n", wait_n, 0);
        chk("acc_sel", sel, xsel);
        chk("acc_berr_n", berr_n, 1);
        chk("lat_addr", lat_addr, a);
        chk("lat_rw_n", lat_rw_n, rd);
        chk("lat_be_n", lat_be_n, {weu, wel});
        if (noise) begin
            addr = 23'($urandom); rw_n = 1'($urandom); wel_n = 1'($urandom); weu_n = 1'($urandom);
        end
        if (win < 0) begin
            @(negedge clk);
            chk("unm_berr_n", berr_n, 0);
            chk("unm_wait_n", wait_n, 1);
            chk("unm_sel", sel, 0);
            erred = 1'b1;
        end else begin
            c = 1;
            forever begin
                bus     = {$urandom, $urandom};
                slv_ack = 4'b0000;
                if (c == k) begin
                    bus[win*16 +: 16] = d;
                    slv_ack[win]      = 1'b1;
                end else if (noise) begin
                    j = $urandom_range(0, 3);
                    if (j != win) slv_ack[j] = 1'b1;
                end
                slv_rdata = bus;
                if (noise) go_n = 1'($urandom);
                @(negedge clk);
                slv_ack = 4'b0000;
                if (c == k) begin
                    if (rd) exp_rdata = d;
                    chk("done_sel", sel, 0);
                    chk("done_wait_n", wait_n, 1);
                    chk("done_berr_n", berr_n, 1);
                    chk("done_rdata", rdata, exp_rdata);
                    break;
                end
                if (TO_EN && c == TB_TO) begin
                    chk("to_sel", sel, 0);
                    chk("to_wait_n", wait_n, 1);
                    chk("to_berr_n", berr_n, 0);
                    erred = 1'b1;
                    break;
                end
                chk("sel_held", sel, xsel);
                chk("sel_wait_n", wait_n, 0);
                chk("sel_berr_n", berr_n, 1);
                c++;
            end
        end
        go_n = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_wait_n", wait_n, 1);
            chk("hold_berr_n", berr_n, !erred);
            chk("hold_sel", sel, 0);
        end
        go_n = 1'b1;
        @(negedge clk);
        chk("idle_wait_n", wait_n, 1);
        chk("idle_berr_n", berr_n, 1);
        chk("idle_sel", sel, 0);
        chk("idle_rdata", rdata, exp_rdata);
    endtask

    initial begin
        logic [22:0] a, b, m;
        int          w;
        reset = 1'b1; addr = '0; go_n = 1'b1; go_n_ov = 1'b1; rw_n = 1'b1;
        wel_n = 1'b1; weu_n = 1'b1; slv_ack = '0; slv_ack_ov = '0;
        slv_rdata = '0; slv_rdata_ov = '0;
        repeat (2) @(negedge clk);
        chk("rst_wait_n", wait_n, 1);
        chk("rst_berr_n", berr_n, 1);
        chk("rst_sel", sel, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_lat", {lat_addr, lat_rw_n, lat_be_n}, 0);
        chk("rst_ov_sel", sel_ov, 0);
        reset = 1'b0;
        @(negedge clk);

        do_txn(23'h000100, 1'b1, 1'b1, 1'b1, 3, 16'hBEEF, 0, 1'b0);
        do_txn(23'h781800, 1'b0, 1'b0, 1'b1, 2, 16'h1234, 1, 1'b0);
        do_txn(23'h600000, 1'b1, 1'b1, 1'b1, 1, 16'h0000, 2, 1'b0);
        do_txn(23'h780000, 1'b1, 1'b1, 1'b1, 1001, 16'hA5C3, 0, 1'b0);

        // Overlapping windows 0 and 1: slave 1 ack must be ignored.
        addr = 23'h123456; rw_n = 1'b1; go_n_ov = 1'b0;
        w = find_win(23'h123456, TB_BASE, TB_MASK_OV);
        @(negedge clk);
        chk("ov_sel", sel_ov, 4'(1 << w));
        slv_ack_ov = 4'b0010; slv_rdata_ov = 64'h0000_0000_DEAD_0000;
        @(negedge clk);
        chk("ov_ignore_sel", sel_ov, 4'(1 << w));
        chk("ov_ignore_wait_n", wait_n_ov, 0);
        slv_ack_ov = 4'b0001; slv_rdata_ov = 64'h0000_0000_DEAD_C0DE;
        @(negedge clk);
        slv_ack_ov = 4'b0000;
        chk("ov_done_sel", sel_ov, 0);
        chk("ov_done_wait_n", wait_n_ov, 1);
        chk("ov_rdata", rdata_ov, 16'hC0DE);
        go_n_ov = 1'b1;
        @(negedge clk);

        // Reset while a cycle is selected and waiting.
        addr = 23'h700010; rw_n = 1'b1; wel_n = 1'b0; weu_n = 1'b0; go_n = 1'b0;
        @(negedge clk);
        chk("mid_sel", sel, 4'b0010);
        reset = 1'b1;
        @(negedge clk);
        exp_rdata = 16'h0000;
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_wait_n", wait_n, 1);
        chk("mid_rst_berr_n", berr_n, 1);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_lat", {lat_addr, lat_rw_n, lat_be_n}, 0);
        reset = 1'b0; go_n = 1'b1;
        @(negedge clk);
        chk("mid_idle_wait_n", wait_n, 1);

        for (int n = 0; n < 40; n++) begin
            w = $urandom_range(0, 4);
            if (w < 4) begin
                b = TB_BASE[w*23 +: 23];
                m = TB_MASK[w*23 +: 23];
                a = (b & m) | (23'($urandom) & ~m);
            end else begin
                a = 23'($urandom);
            end
            do_txn(a, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 6),
                   16'($urandom), $urandom_range(0, 2), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
